// File: rtl/fb_write_arbiter.sv
// Framebuffer RAM write-port arbiter: round-robin between two requesters plus a
// whole-RAM fill engine; forwards the display read port with a read-valid flag.
module fb_write_arbiter #(
    parameter int DATA_WIDTH = 15,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_data,
    output logic                  clr_busy,
    output logic                  clr_done,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_next;
    logic                  last_b;
    logic [ADDR_WIDTH-1:0] counter;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  grant_a, grant_b;

    // Arbitration and next state; a tie goes to whoever did not win last time.
    always_comb begin
        state_next = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_next = CLEAR;
                end else begin
                    grant_a = a_valid && (!b_valid || last_b);
                    grant_b = b_valid && (!a_valid || !last_b);
                end
            end
            CLEAR: begin
                if (counter == '1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign a_ready       = grant_a;
    assign b_ready       = grant_b;
    assign ram_read_addr = rd_addr;

    // Registered RAM write port; counter always equals the fill address on ram_write_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_b         <= 1'b1;
            counter        <= '0;
            fill_data      <= '0;
            clr_busy       <= 1'b0;
            clr_done       <= 1'b0;
            rd_valid       <= 1'b0;
            ram_we         <= 1'b0;
            ram_write_addr <= '0;
            ram_data       <= '0;
        end else begin
            state    <= state_next;
            rd_valid <= rd_req;
            clr_done <= 1'b0;
            ram_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        counter        <= '0;
                        fill_data      <= clr_data;
                        clr_busy       <= 1'b1;
                        ram_we         <= 1'b1;
                        ram_write_addr <= '0;
                        ram_data       <= clr_data;
                    end else if (grant_a) begin
                        last_b         <= 1'b0;
                        ram_we         <= 1'b1;
                        ram_write_addr <= a_addr;
                        ram_data       <= a_data;
                    end else if (grant_b) begin
                        last_b         <= 1'b1;
                        ram_we         <= 1'b1;
                        ram_write_addr <= b_addr;
                        ram_data       <= b_data;
                    end
                end
                CLEAR: begin
                    if (counter == '1) begin
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        counter        <= counter + ADDR_WIDTH'(1);
                        ram_we         <= 1'b1;
                        ram_write_addr <= counter + ADDR_WIDTH'(1);
                        ram_data       <= fill_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter (ADDR_WIDTH=4): expected writes are queued
// by the stimulus and checked by a monitor watching the RAM write port.
module tb_fb_write_arbiter;

    localparam int DW = 15;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_data = '0;
    logic          clr_busy, clr_done;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic          ram_we;
    logic [AW-1:0] ram_write_addr, ram_read_addr;
    logic [DW-1:0] ram_data;

    fb_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy), .clr_done(clr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_data(ram_data),
        .ram_read_addr(ram_read_addr)
    );

    always #5 clk = ~clk;

    // Behavioural framebuffer RAM with a registered read port.
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_write_addr] <= ram_data;
        q <= mem[ram_read_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            at;
    } wr_t;
    wr_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int at);
        wr_t w;
        w.addr = addr;
        w.data = data;
        w.at   = at;
        exp_q.push_back(w);
    endtask

    // One cycle: check handshake/status mid-cycle, queue any granted write, advance.
    task automatic tick(input logic ea, input logic eb, input logic ebusy, input logic edone,
                        input string tag);
        @(negedge clk);
        chk({tag, " a_ready"}, 32'(a_ready), 32'(ea));
        chk({tag, " b_ready"}, 32'(b_ready), 32'(eb));
        chk({tag, " clr_busy"}, 32'(clr_busy), 32'(ebusy));
        chk({tag, " clr_done"}, 32'(clr_done), 32'(edone));
        if (ea) push(a_addr, a_data, cyc + 1);
        if (eb) push(b_addr, b_data, cyc + 1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && ram_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected write: addr %0h data %0h (cycle %0d)",
                         ram_write_addr, ram_data, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write addr", 32'(ram_write_addr), 32'(e.addr));
                chk("write data", 32'(ram_data), 32'(e.data));
                chk("write cycle", cyc, e.at);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset ram_we", 32'(ram_we), 0);
        chk("reset ram_write_addr", 32'(ram_write_addr), 0);
        chk("reset ram_data", 32'(ram_data), 0);
        chk("reset clr_busy", 32'(clr_busy), 0);
        chk("reset clr_done", 32'(clr_done), 0);
        chk("reset rd_valid", 32'(rd_valid), 0);
        rst_n = 1'b1;

        // Both requesters valid from reset: A wins the first tie, then alternate.
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_addr = AW'(8 + i);
            a_data = DW'(15'h0A00 + i);
            b_addr = AW'(12 + i);
            b_data = DW'(15'h0B00 + i);
            tick(i % 2 == 0, i % 2 == 1, 1'b0, 1'b0, "alt");
        end
        b_valid = 1'b0;

        // A alone, addresses 1..3 back to back.
        for (int i = 1; i <= 3; i++) begin
            a_addr = AW'(i);
            a_data = DW'(15'h0100 + i);
            tick(1'b1, 1'b0, 1'b0, 1'b0, "a only");
        end
        a_valid = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, "idle");

        // Fill with A stalled throughout; clr_data changes after the start cycle.
        a_valid   = 1'b1;
        a_addr    = 4'd5;
        a_data    = 15'h0555;
        clr_start = 1'b1;
        clr_data  = 15'h7FFF;
        for (int k = 0; k < 16; k++) push(AW'(k), 15'h7FFF, cyc + 1 + k);
        tick(1'b0, 1'b0, 1'b0, 1'b0, "clr start");
        clr_start = 1'b0;
        clr_data  = 15'h0000;
        for (int k = 0; k < 16; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, "clr run");
        tick(1'b1, 1'b0, 1'b0, 1'b1, "clr exit");
        a_valid = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, "post clr");

        // Reset asserted while the fill is writing address 4.
        clr_start = 1'b1;
        clr_data  = 15'h1234;
        for (int k = 0; k < 5; k++) push(AW'(k), 15'h1234, cyc + 1 + k);
        tick(1'b0, 1'b0, 1'b0, 1'b0, "abort start");
        clr_start = 1'b0;
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, "abort run");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort ram_we", 32'(ram_we), 0);
        chk("abort ram_write_addr", 32'(ram_write_addr), 0);
        chk("abort ram_data", 32'(ram_data), 0);
        chk("abort clr_busy", 32'(clr_busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, "after abort");
        tick(1'b0, 1'b0, 1'b0, 1'b0, "after abort");
        a_valid = 1'b1;
        a_addr  = 4'd6;
        a_data  = 15'h0666;
        tick(1'b1, 1'b0, 1'b0, 1'b0, "a after abort");

        // Write 3 then read 3 in the write cycle (old word) and again (new word).
        a_addr = 4'd3;
        a_data = 15'h0333;
        tick(1'b1, 1'b0, 1'b0, 1'b0, "a wr3");
        a_valid = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 4'd3;
        @(negedge clk);
        chk("ram_read_addr", 32'(ram_read_addr), 3);
        chk("rd_valid idle", 32'(rd_valid), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rd_valid 1", 32'(rd_valid), 1);
        chk("read old word", 32'(q), 32'h1234);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_valid 2", 32'(rd_valid), 1);
        chk("read new word", 32'(q), 32'h0333);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rd_valid drop", 32'(rd_valid), 0);
        @(posedge clk);
        #1;

        // Tie after an A win goes to B, then A proceeds.
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_addr  = 4'd7;
        a_data  = 15'h0777;
        b_addr  = 4'd9;
        b_data  = 15'h0999;
        tick(1'b0, 1'b1, 1'b0, 1'b0, "tie b");
        b_valid = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, "then a");
        a_valid = 1'b0;

        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, "drain");
        chk("writes outstanding", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
